// File: rtl/switch_debounce_filter.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce_filter
// Description : Debounces one raw switch; emits a clean level plus press,
//               release and hold-event strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce_filter #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HOLD_LIMIT     = 25000000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Hold,
  output logic o_Hold_Pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_LIMIT);
  localparam int HOLD_W = $clog2(HOLD_LIMIT);
  localparam logic [DB_W-1:0]   c_DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_LIMIT - 1);

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } state_t;

  logic              r_sync_meta;
  logic              r_sync;
  state_t            r_state;
  state_t            w_state_next;
  logic [DB_W-1:0]   r_db_cnt;
  logic [DB_W-1:0]   w_db_cnt_next;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_next;
  logic              w_switch_next;
  logic              w_press_next;
  logic              w_release_next;
  logic              w_hold_next;
  logic              w_hold_pulse_next;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_sync_meta  <= 1'b0;
      r_sync       <= 1'b0;
      r_state      <= S_LOW;
      r_db_cnt     <= '0;
      r_hold_cnt   <= '0;
      o_Switch     <= 1'b0;
      o_Press      <= 1'b0;
      o_Release    <= 1'b0;
      o_Hold       <= 1'b0;
      o_Hold_Pulse <= 1'b0;
    end else begin
      r_sync_meta  <= i_Switch;
      r_sync       <= r_sync_meta;
      r_state      <= w_state_next;
      r_db_cnt     <= w_db_cnt_next;
      r_hold_cnt   <= w_hold_cnt_next;
      o_Switch     <= w_switch_next;
      o_Press      <= w_press_next;
      o_Release    <= w_release_next;
      o_Hold       <= w_hold_next;
      o_Hold_Pulse <= w_hold_pulse_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_db_cnt_next     = r_db_cnt;
    w_hold_cnt_next   = r_hold_cnt;
    w_switch_next     = o_Switch;
    w_press_next      = 1'b0;
    w_release_next    = 1'b0;
    w_hold_next       = o_Hold;
    w_hold_pulse_next = 1'b0;

    // Hold timer runs while pressed; it stops at the threshold so it fires once.
    if ((r_state == S_HIGH || r_state == S_FALL_CHK) && !o_Hold) begin
      if (r_hold_cnt == c_HOLD_LAST) begin
        w_hold_next       = 1'b1;
        w_hold_pulse_next = 1'b1;
      end else begin
        w_hold_cnt_next = r_hold_cnt + 1'b1;
      end
    end

    case (r_state)
      S_LOW: begin
        if (r_sync) begin
          w_state_next  = S_RISE_CHK;
          w_db_cnt_next = DB_W'(1);
        end
      end
      S_RISE_CHK: begin
        if (!r_sync) begin
          w_state_next = S_LOW;
        end else if (r_db_cnt == c_DB_LAST) begin
          w_state_next    = S_HIGH;
          w_switch_next   = 1'b1;
          w_press_next    = 1'b1;
          w_hold_cnt_next = '0;
          w_hold_next     = 1'b0;
        end else begin
          w_db_cnt_next = r_db_cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!r_sync) begin
          w_state_next  = S_FALL_CHK;
          w_db_cnt_next = DB_W'(1);
        end
      end
      S_FALL_CHK: begin
        if (r_sync) begin
          w_state_next = S_HIGH;
        end else if (r_db_cnt == c_DB_LAST) begin
          // Release overrides a hold threshold landing on the same edge.
          w_state_next      = S_LOW;
          w_switch_next     = 1'b0;
          w_release_next    = 1'b1;
          w_hold_cnt_next   = '0;
          w_hold_next       = 1'b0;
          w_hold_pulse_next = 1'b0;
        end else begin
          w_db_cnt_next = r_db_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_LOW;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debounce_filter
// Description : Directed self-checking bench for switch_debounce_filter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debounce_filter;

  logic i_Clk = 1'b0;
  logic i_Rst_L;
  logic i_Switch;
  logic o_Switch;
  logic o_Press;
  logic o_Release;
  logic o_Hold;
  logic o_Hold_Pulse;

  int n_checks = 0;
  int n_fail   = 0;

  switch_debounce_filter #(
    .DEBOUNCE_LIMIT(4),
    .HOLD_LIMIT    (20)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Switch    (i_Switch),
    .o_Switch    (o_Switch),
    .o_Press     (o_Press),
    .o_Release   (o_Release),
    .o_Hold      (o_Hold),
    .o_Hold_Pulse(o_Hold_Pulse)
  );

  always #5 i_Clk = ~i_Clk;

  // Output vector order: {o_Switch, o_Press, o_Release, o_Hold, o_Hold_Pulse}
  task automatic tick_check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    @(posedge i_Clk);
    #1;
    obs = {o_Switch, o_Press, o_Release, o_Hold, o_Hold_Pulse};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // n-1 edges expecting mid, then the nth edge expecting fin.
  task automatic run_edges(input string tag, input int n,
                           input logic [4:0] mid, input logic [4:0] fin);
    for (int k = 1; k < n; k++) tick_check(tag, mid);
    tick_check({tag, "_final"}, fin);
  endtask

  initial begin
    i_Rst_L  = 1'b0;
    i_Switch = 1'b1;

    // 1: reset held with switch high, press arrives on 6th edge after release
    for (int k = 0; k < 10; k++) tick_check("reset_hold", 5'b00000);
    i_Rst_L = 1'b1;
    run_edges("reset_exit_press", 6, 5'b00000, 5'b11000);
    tick_check("reset_exit_press_1cyc", 5'b10000);
    i_Switch = 1'b0;
    run_edges("reset_exit_release", 6, 5'b10000, 5'b00100);
    tick_check("reset_exit_release_1cyc", 5'b00000);

    // 2: clean press
    i_Switch = 1'b1;
    run_edges("clean_press", 6, 5'b00000, 5'b11000);
    tick_check("clean_press_1cyc", 5'b10000);
    i_Switch = 1'b0;
    run_edges("clean_release", 6, 5'b10000, 5'b00100);
    tick_check("clean_release_1cyc", 5'b00000);

    // 3: bounce 1x3, 0x2, then stable 1
    i_Switch = 1'b1;
    for (int k = 0; k < 3; k++) tick_check("bounce_hi", 5'b00000);
    i_Switch = 1'b0;
    for (int k = 0; k < 2; k++) tick_check("bounce_lo", 5'b00000);
    i_Switch = 1'b1;
    run_edges("bounce_press", 6, 5'b00000, 5'b11000);

    // 4: hold fires 20 edges after o_Switch rises, release clears it
    tick_check("hold_wait_first", 5'b10000);
    run_edges("hold_fire", 19, 5'b10000, 5'b10011);
    tick_check("hold_pulse_1cyc", 5'b10010);
    i_Switch = 1'b0;
    run_edges("hold_release", 6, 5'b10010, 5'b00100);
    tick_check("hold_release_1cyc", 5'b00000);

    // 5: release glitch of 3 cycles, hold timer keeps counting
    i_Switch = 1'b1;
    run_edges("glitch_press", 6, 5'b00000, 5'b11000);
    i_Switch = 1'b0;
    tick_check("glitch_lo1", 5'b10000);
    tick_check("glitch_lo2", 5'b10000);
    tick_check("glitch_lo3", 5'b10000);
    i_Switch = 1'b1;
    run_edges("glitch_hold", 17, 5'b10000, 5'b10011);
    tick_check("glitch_hold_after", 5'b10010);

    // 6: reset mid-press with hold active, no release strobe
    i_Rst_L = 1'b0;
    tick_check("midreset_edge", 5'b00000);
    tick_check("midreset_held", 5'b00000);
    i_Rst_L = 1'b1;
    run_edges("midreset_repress", 6, 5'b00000, 5'b11000);

    // Release landing on the hold-threshold edge: release wins, no pulse
    run_edges("tie_wait", 14, 5'b10000, 5'b10000);
    i_Switch = 1'b0;
    run_edges("tie_release", 6, 5'b10000, 5'b00100);
    tick_check("tie_after", 5'b00000);
    tick_check("tie_quiet", 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
